// File: rtl/ofdm_pkg.sv
// -----------------------------------------------------------------------------
// ofdm_pkg
// Shared constants and types for the OFDM datapath.
//   OFDM_N  : samples per OFDM symbol (power of two)
//   OFDM_CP : cyclic-prefix length in samples
//   OFDM_W  : signed sample width per rail
//   cplx_t  : packed complex sample {re, im}
//   cp_state_t : read-side state of the cyclic-prefix inserter
// -----------------------------------------------------------------------------
package ofdm_pkg;

  localparam int unsigned OFDM_N  = 64;
  localparam int unsigned OFDM_CP = 16;
  localparam int unsigned OFDM_W  = 16;

  typedef struct packed {
    logic signed [OFDM_W-1:0] re;
    logic signed [OFDM_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    StIdle,
    StPrefix,
    StBody
  } cp_state_t;

endpackage

// File: rtl/cp_buf.sv
// -----------------------------------------------------------------------------
// cp_buf
// Simple dual-port RAM: one write port, one synchronous (1-cycle) read port.
// Address is {bank, idx}; contents are not reset.
// Ports:
//   clk       : clock
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_en   : read strobe; o_rd_data updates on the next edge
//   i_rd_addr : read address
//   o_rd_data : registered read data (holds when i_rd_en is low)
// -----------------------------------------------------------------------------
module cp_buf
  import ofdm_pkg::*;
#(
  parameter int unsigned Depth = 2 * OFDM_N,
  parameter int unsigned Width = 2 * OFDM_W
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(Depth)-1:0] i_wr_addr,
  input  logic [Width-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(Depth)-1:0] i_rd_addr,
  output logic [Width-1:0]         o_rd_data
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/cp_insert.sv
// -----------------------------------------------------------------------------
// cp_insert
// Cyclic-prefix insertion stage. Collects N-sample IFFT symbols (possibly
// gapped) into a two-bank ping-pong buffer and emits each as N+CP contiguous
// samples: the last CP samples first, then all N.
// Ports:
//   clk      : clock
//   reset    : asynchronous, active-high reset
//   din_en   : input sample valid (no backpressure)
//   din_re   : signed real input
//   din_im   : signed imaginary input
//   dout_en  : output sample valid
//   dout_re  : signed real output (0 when dout_en is low)
//   dout_im  : signed imaginary output (0 when dout_en is low)
//   dout_sop : first prefix sample of each symbol
//   dout_cp  : prefix samples
//   overflow : sticky; an input sample was dropped because both banks were full
// -----------------------------------------------------------------------------
module cp_insert
  import ofdm_pkg::*;
#(
  parameter int unsigned N  = OFDM_N,
  parameter int unsigned CP = OFDM_CP,
  parameter int unsigned W  = OFDM_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din_en,
  input  logic signed [W-1:0] din_re,
  input  logic signed [W-1:0] din_im,
  output logic                dout_en,
  output logic signed [W-1:0] dout_re,
  output logic signed [W-1:0] dout_im,
  output logic                dout_sop,
  output logic                dout_cp,
  output logic                overflow
);

  localparam int unsigned IdxW = $clog2(N);
  localparam logic [IdxW-1:0] IdxLast    = IdxW'(N - 1);
  localparam logic [IdxW-1:0] IdxCpStart = IdxW'(N - CP);

  // ---------------------------------------------------------------------------
  // Bank occupancy
  // ---------------------------------------------------------------------------
  logic [1:0] r_full;
  logic [1:0] w_full_nxt;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic            r_wbank;
  logic [IdxW-1:0] r_wcnt;
  logic            r_overflow;
  logic            w_wr_en;
  logic            w_wr_last;

  assign w_wr_en   = din_en & ~r_full[r_wbank];
  assign w_wr_last = w_wr_en & (r_wcnt == IdxLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wbank    <= 1'b0;
      r_wcnt     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        // N is a power of two, so the index wraps to 0 after the last sample.
        r_wcnt <= r_wcnt + 1'b1;
        if (w_wr_last) begin
          r_wbank <= ~r_wbank;
        end
      end
      if (din_en & r_full[r_wbank]) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  cp_state_t       r_state;
  cp_state_t       w_state_nxt;
  logic            r_rbank;
  logic            w_rbank_nxt;
  logic [IdxW-1:0] r_rcnt;
  logic [IdxW-1:0] w_rcnt_nxt;
  logic            w_rd_en;
  logic            w_rd_last;
  logic            w_sop;
  logic            w_cp;

  always_comb begin
    w_state_nxt = r_state;
    w_rbank_nxt = r_rbank;
    w_rcnt_nxt  = r_rcnt;
    w_rd_en     = 1'b0;
    w_rd_last   = 1'b0;
    w_sop       = 1'b0;
    w_cp        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_full[r_rbank]) begin
          w_state_nxt = StPrefix;
          w_rcnt_nxt  = IdxCpStart;
        end
      end
      StPrefix: begin
        w_rd_en    = 1'b1;
        w_cp       = 1'b1;
        w_sop      = (r_rcnt == IdxCpStart);
        w_rcnt_nxt = r_rcnt + 1'b1;
        if (r_rcnt == IdxLast) begin
          w_state_nxt = StBody;
          w_rcnt_nxt  = '0;
        end
      end
      StBody: begin
        w_rd_en    = 1'b1;
        w_rcnt_nxt = r_rcnt + 1'b1;
        if (r_rcnt == IdxLast) begin
          w_rd_last   = 1'b1;
          w_rbank_nxt = ~r_rbank;
          // Chain straight into the next symbol so the output stays continuous.
          if (r_full[~r_rbank]) begin
            w_state_nxt = StPrefix;
            w_rcnt_nxt  = IdxCpStart;
          end else begin
            w_state_nxt = StIdle;
            w_rcnt_nxt  = '0;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_rcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_rbank <= 1'b0;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rbank <= w_rbank_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Full flags: set by the writer, cleared by the reader. The writer never
  // targets the bank being read, so both updates can apply in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last) begin
      w_full_nxt[r_wbank] = 1'b1;
    end
    if (w_rd_last) begin
      w_full_nxt[r_rbank] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample storage
  // ---------------------------------------------------------------------------
  logic [2*W-1:0] w_rd_data;

  cp_buf #(
    .Depth (2 * N),
    .Width (2 * W)
  ) u_cp_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr ({r_wbank, r_wcnt}),
    .i_wr_data ({din_re, din_im}),
    .i_rd_en   (w_rd_en),
    .i_rd_addr ({r_rbank, r_rcnt}),
    .o_rd_data (w_rd_data)
  );

  // ---------------------------------------------------------------------------
  // Output stage: flags are registered alongside the RAM read so they line up
  // with the data. The RAM register itself is not reset, so data is gated by
  // the valid flag to give 0 when idle and immediately on reset.
  // ---------------------------------------------------------------------------
  logic r_dout_en;
  logic r_dout_sop;
  logic r_dout_cp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout_en  <= 1'b0;
      r_dout_sop <= 1'b0;
      r_dout_cp  <= 1'b0;
    end else begin
      r_dout_en  <= w_rd_en;
      r_dout_sop <= w_sop;
      r_dout_cp  <= w_cp;
    end
  end

  assign dout_en  = r_dout_en;
  assign dout_sop = r_dout_sop;
  assign dout_cp  = r_dout_cp;
  assign dout_re  = r_dout_en ? w_rd_data[2*W-1:W] : '0;
  assign dout_im  = r_dout_en ? w_rd_data[W-1:0]   : '0;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_cp_insert.sv
`timescale 1ns/1ps
module tb_cp_insert;

  localparam int N     = 64;
  localparam int CP    = 16;
  localparam int W     = 16;
  localparam int FRAME = N + CP;

  logic                clk = 1'b0;
  logic                reset;
  logic                din_en;
  logic signed [W-1:0] din_re;
  logic signed [W-1:0] din_im;
  logic                dout_en;
  logic signed [W-1:0] dout_re;
  logic signed [W-1:0] dout_im;
  logic                dout_sop;
  logic                dout_cp;
  logic                overflow;

  cp_insert #(
    .N  (N),
    .CP (CP),
    .W  (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .din_en   (din_en),
    .din_re   (din_re),
    .din_im   (din_im),
    .dout_en  (dout_en),
    .dout_re  (dout_re),
    .dout_im  (dout_im),
    .dout_sop (dout_sop),
    .dout_cp  (dout_cp),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output capture: {sop, cp, re, im} plus the cycle stamp of each valid sample.
  logic [33:0] q_out[$];
  int          q_cyc[$];

  always @(negedge clk) begin
    if (dout_en) begin
      q_out.push_back({dout_sop, dout_cp, dout_re, dout_im});
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Expected output word j (0..FRAME-1) of a symbol whose sample k is base+k.
  function automatic logic [33:0] exp_word(input int base, input int j);
    int         idx;
    logic [W-1:0] re;
    logic [W-1:0] im;
    idx = (j < CP) ? (N - CP + j) : (j - CP);
    re  = W'(base + idx);
    im  = W'(-(base + idx));
    return {(j == 0), (j < CP), re, im};
  endfunction

  // Caller is aligned to 1ns after a rising edge.
  task automatic drive_sample(input int v);
    din_en = 1'b1;
    din_re = W'(v);
    din_im = W'(-v);
    last_edge = cyc + 1;
    @(posedge clk); #1;
    din_en = 1'b0;
    din_re = '0;
    din_im = '0;
  endtask

  // gap < 0 selects a random 0..3 idle cycles after each sample.
  task automatic send(input int base, input int count, input int gap);
    int g;
    for (int i = 0; i < count; i++) begin
      drive_sample(base + i);
      g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      repeat (g) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    din_en = 1'b0;
    din_re = '0;
    din_im = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    q_out.delete();
    q_cyc.delete();
    @(posedge clk); #1;
  endtask

  task automatic wait_samples(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (q_out.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_arrived"}, q_out.size() >= n, 1);
  endtask

  task automatic check_frame(input string tag, input int start, input int base);
    if (q_out.size() < start + FRAME) begin
      check({tag, "_len"}, q_out.size(), start + FRAME);
      return;
    end
    for (int j = 0; j < FRAME; j++)
      check($sformatf("%s[%0d]", tag, j), q_out[start + j], exp_word(base, j));
    check({tag, "_contig"}, q_cyc[start + FRAME - 1] - q_cyc[start], FRAME - 1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    din_en = 1'b0;
    din_re = '0;
    din_im = '0;
    #1;
    check("rst_dout_en", dout_en, 0);
    check("rst_sop", dout_sop, 0);
    check("rst_cp", dout_cp, 0);
    check("rst_ovf", overflow, 0);
    check("rst_data", {dout_re, dout_im}, 0);

    // 1: single symbol, continuous input, latency of two edges.
    do_reset();
    send(0, N, 0);
    wait_samples("t1", FRAME, 200);
    if (q_cyc.size() > 0) check("t1_latency", q_cyc[0] - last_edge, 2);
    check_frame("t1", 0, 0);
    repeat (20) @(posedge clk); #1;
    check("t1_count", q_out.size(), FRAME);

    // 2: two symbols at half rate.
    do_reset();
    send(0, N, 1);
    send(100, N, 1);
    wait_samples("t2", 2 * FRAME, 300);
    check_frame("t2a", 0, 0);
    check_frame("t2b", FRAME, 100);
    check("t2_ovf", overflow, 0);

    // 3: three symbols back to back; third overruns and stays incomplete.
    do_reset();
    send(0, 3 * N, 0);
    wait_samples("t3", 2 * FRAME, 400);
    check_frame("t3a", 0, 0);
    check_frame("t3b", FRAME, N);
    if (q_cyc.size() >= 2 * FRAME)
      check("t3_no_gap", q_cyc[2 * FRAME - 1] - q_cyc[0], 2 * FRAME - 1);
    repeat (150) @(posedge clk); #1;
    check("t3_no_sym3", q_out.size(), 2 * FRAME);
    check("t3_ovf", overflow, 1);

    // 4: randomly gapped input gives the same frames.
    do_reset();
    send(0, N, -1);
    send(200, N, -1);
    wait_samples("t4", 2 * FRAME, 400);
    check_frame("t4a", 0, 0);
    check_frame("t4b", FRAME, 200);
    check("t4_ovf", overflow, 0);

    // 5: reset at output sample 30, then a fresh symbol.
    do_reset();
    send(0, N, 0);
    wait_samples("t5_pre", 30, 200);
    check("t5_pre_en", dout_en, 1);
    reset = 1'b1;
    #1;
    check("t5_rst_en", dout_en, 0);
    check("t5_rst_flags", {dout_sop, dout_cp}, 0);
    check("t5_rst_data", {dout_re, dout_im}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q_out.delete();
    q_cyc.delete();
    repeat (100) @(posedge clk); #1;
    check("t5_no_residue", q_out.size(), 0);
    send(300, N, 0);
    wait_samples("t5", FRAME, 200);
    check_frame("t5", 0, 300);

    // 6: reset with 40 samples written; next 64 form a clean symbol.
    do_reset();
    send(500, 40, 0);
    do_reset();
    send(600, N, 0);
    wait_samples("t6", FRAME, 200);
    check_frame("t6", 0, 600);
    repeat (100) @(posedge clk); #1;
    check("t6_count", q_out.size(), FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
